// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared across the MIPS core.
//   REG_AW     - register address width
//   NUM_REGS   - number of general-purpose registers
//   reg_addr_t - register address type
package cpu_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : cpu_pkg

// File: rtl/sb_counter.sv
// sb_counter: one saturating up/down counter of outstanding writes for a
// single register.
//   clk          - clock, rising edge
//   reset        - synchronous, active-high; clears the count
//   inc          - accepted issue targeting this register
//   dec          - retirement targeting this register
//   count        - current number of outstanding writes
//   sat          - count is at its maximum value
//   zero_dec_err - a retirement arrived while count is zero
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat,
    output logic         zero_dec_err
);

    assign sat          = (count == {W{1'b1}});
    assign zero_dec_err = dec & (count == '0);

    // Simultaneous inc and dec cancel out. The caller only raises inc on an
    // accepted issue, but the sat guard keeps the counter from wrapping anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !sat) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks outstanding writes to the 32 general-purpose
// registers so decode can detect read-after-write hazards.
//
// Optional feature macro: SCOREBOARD_BYPASS_EN. When defined, a source whose
// only outstanding write is retiring this cycle is reported not busy,
// matching the register file's write-through of WD onto RD1/RD2.
//
// Ports:
//   clk, reset               - clock; synchronous active-high reset
//   issue_valid, issue_rd    - decode issues an instruction writing issue_rd
//   issue_ready              - the issue is accepted this cycle
//   retire_valid, retire_rd  - register-file write strobe and address
//   rs_addr, rt_addr         - decode source addresses
//   rs_busy, rt_busy         - source has an uncommitted write
//   stall                    - decode must hold this cycle
//   err                      - sticky: retire seen on a zero counter
//
// Issue handshake: an issue takes effect on the rising edge where
// issue_valid and issue_ready are both high; issue_ready is combinational
// from the current counters and the same-cycle retire, and issue_valid with
// issue_ready low changes no state. Retire has no back-pressure.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    output logic      issue_ready,
    input  logic      retire_valid,
    input  reg_addr_t retire_rd,
    input  reg_addr_t rs_addr,
    input  reg_addr_t rt_addr,
    output logic      rs_busy,
    output logic      rt_busy,
    output logic      stall,
    output logic      err
);

    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic             sat     [NUM_REGS];
    logic             zerr    [NUM_REGS];
    logic [NUM_REGS-1:0] zerr_vec;
    logic             issue_fire;
    logic             retire_same;

    // $0 has no storage: it always reads as an empty, unsaturated counter.
    assign cnt[0]      = '0;
    assign sat[0]      = 1'b0;
    assign zerr[0]     = 1'b0;
    assign zerr_vec[0] = 1'b0;

    // A retire to the same register frees a slot this cycle, so a saturated
    // counter may still take the issue (the counter then stays unchanged).
    assign retire_same = retire_valid && (retire_rd == issue_rd);
    assign issue_ready = (issue_rd == '0) || !sat[issue_rd] || retire_same;
    assign issue_fire  = issue_valid && issue_ready;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        sb_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .inc         (issue_fire && (issue_rd == reg_addr_t'(i))),
            .dec         (retire_valid && (retire_rd == reg_addr_t'(i))),
            .count       (cnt[i]),
            .sat         (sat[i]),
            .zero_dec_err(zerr[i])
        );
        assign zerr_vec[i] = zerr[i];
    end

    always_comb begin
        rs_busy = (rs_addr != '0) && (cnt[rs_addr] != '0);
        rt_busy = (rt_addr != '0) && (cnt[rt_addr] != '0);
`ifdef SCOREBOARD_BYPASS_EN
        // The last outstanding write is landing now and the register file
        // forwards it, so the reader sees the new value this cycle.
        if (retire_valid && (retire_rd == rs_addr) &&
            (cnt[rs_addr] == CNT_W'(1))) begin
            rs_busy = 1'b0;
        end
        if (retire_valid && (retire_rd == rt_addr) &&
            (cnt[rt_addr] == CNT_W'(1))) begin
            rt_busy = 1'b0;
        end
`endif
    end

    assign stall = rs_busy || rt_busy || (issue_valid && !issue_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (|zerr_vec) begin
            err <= 1'b1;
        end
    end

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic       retire_valid;
    logic [4:0] retire_rd;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic       rs_busy;
    logic       rt_busy;
    logic       stall;
    logic       err;

    int errors = 0;
    int checks = 0;

`ifdef SCOREBOARD_BYPASS_EN
    localparam logic BYP_BUSY = 1'b0;
`else
    localparam logic BYP_BUSY = 1'b1;
`endif

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .retire_valid(retire_valid),
        .retire_rd   (retire_rd),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .stall       (stall),
        .err         (err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        retire_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_rd = '0;
        retire_valid = 1'b0; retire_rd = '0; rs_addr = '0; rt_addr = '0;
        step(); step();
        reset = 1'b0;

        // Reset state
        rs_addr = 5'd8; rt_addr = 5'd31; issue_rd = 5'd8; #1;
        chk("rst_rs_busy", rs_busy, 1'b0);
        chk("rst_rt_busy", rt_busy, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ready", issue_ready, 1'b1);
        chk("rst_err", err, 1'b0);

        // Issue $8, busy next cycle, retire frees it
        rs_addr = 5'd0; rt_addr = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd8; #1;
        chk("i8_ready", issue_ready, 1'b1);
        chk("i8_stall_same", stall, 1'b0);
        step(); idle();
        rs_addr = 5'd8; #1;
        chk("i8_busy", rs_busy, 1'b1);
        chk("i8_stall", stall, 1'b1);
        retire_valid = 1'b1; retire_rd = 5'd8; #1;
        chk("r8_busy_same", rs_busy, BYP_BUSY);
        step(); idle(); #1;
        chk("r8_busy_after", rs_busy, 1'b0);
        chk("r8_stall_after", stall, 1'b0);

        // $0 is never tracked
        rs_addr = 5'd0; rt_addr = 5'd0;
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_rd = 5'd0; #1;
            chk("i0_ready", issue_ready, 1'b1);
            step();
        end
        idle(); #1;
        chk("i0_rs_busy", rs_busy, 1'b0);
        chk("i0_rt_busy", rt_busy, 1'b0);
        chk("i0_err", err, 1'b0);

        // Saturate $5
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_rd = 5'd5; #1;
            chk("i5_ready", issue_ready, 1'b1);
            step();
        end
        #1;
        chk("i5_sat_ready", issue_ready, 1'b0);
        chk("i5_sat_stall", stall, 1'b0 == 1'b0);
        step();
        // Saturated issue plus same-register retire is accepted
        retire_valid = 1'b1; retire_rd = 5'd5; #1;
        chk("i5_swap_ready", issue_ready, 1'b1);
        chk("i5_swap_stall", stall, 1'b0);
        step();
        retire_valid = 1'b0; #1;
        chk("i5_still_sat", issue_ready, 1'b0);
        idle(); rs_addr = 5'd5; #1;
        chk("i5_busy", rs_busy, 1'b1);
        // Drain three writes
        retire_valid = 1'b1; retire_rd = 5'd5;
        step(); step(); idle(); #1;
        chk("i5_busy_cnt1", rs_busy, 1'b1);
        retire_valid = 1'b1; retire_rd = 5'd5; #1;
        chk("i5_busy_last", rs_busy, BYP_BUSY);
        step(); idle(); #1;
        chk("i5_free", rs_busy, 1'b0);
        chk("i5_err", err, 1'b0);

        // Issue $9 while retiring $12 (cnt 1)
        issue_valid = 1'b1; issue_rd = 5'd12; step(); idle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        retire_valid = 1'b1; retire_rd = 5'd12;
        rs_addr = 5'd9; rt_addr = 5'd12; #1;
        chk("x_rs_busy_same", rs_busy, 1'b0);
        chk("x_rt_busy_same", rt_busy, BYP_BUSY);
        step(); idle(); #1;
        chk("x_rs_busy", rs_busy, 1'b1);
        chk("x_rt_busy", rt_busy, 1'b0);
        chk("x_err", err, 1'b0);
        retire_valid = 1'b1; retire_rd = 5'd9; step(); idle(); #1;
        chk("x9_free", rs_busy, 1'b0);

        // Retire on empty $20 sets sticky err
        rs_addr = 5'd20; rt_addr = 5'd0;
        retire_valid = 1'b1; retire_rd = 5'd20; #1;
        chk("e_err_same", err, 1'b0);
        step(); idle(); #1;
        chk("e_err", err, 1'b1);
        chk("e_busy", rs_busy, 1'b0);
        step(); step(); #1;
        chk("e_err_held", err, 1'b1);
        // Counter stayed 0: one issue makes it 1, one retire frees it
        issue_valid = 1'b1; issue_rd = 5'd20; #1;
        chk("e_ready", issue_ready, 1'b1);
        step(); idle(); #1;
        chk("e_busy1", rs_busy, 1'b1);
        retire_valid = 1'b1; retire_rd = 5'd20; step(); idle(); #1;
        chk("e_free", rs_busy, 1'b0);
        reset = 1'b1; step(); reset = 1'b0; #1;
        chk("e_err_cleared", err, 1'b0);

        // Reset mid-operation
        issue_valid = 1'b1; issue_rd = 5'd3; step(); step(); idle();
        rs_addr = 5'd3; rt_addr = 5'd3; #1;
        chk("m_busy_pre", rs_busy, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        issue_rd = 5'd3; #1;
        chk("m_rs_busy", rs_busy, 1'b0);
        chk("m_rt_busy", rt_busy, 1'b0);
        chk("m_ready", issue_ready, 1'b1);
        chk("m_stall", stall, 1'b0);
        chk("m_err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_scoreboard
